// File: rtl/axi_fifo_write_bridge_pkg.sv
// ============================================================================
// Module   : axi_fifo_write_bridge_pkg
// Brief    : Shared AXI response codes and write-bridge state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_fifo_write_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_PUSH_ENC = 2'd1;
    localparam logic [1:0] ST_RESP_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_PUSH = ST_PUSH_ENC,
        ST_RESP = ST_RESP_ENC
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_fifo_write_bridge_chan_hold.sv
// ============================================================================
// Module   : axi_chan_hold
// Brief    : Single-entry AXI channel holding register with registered ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_chan_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_valid,
    input  logic [W-1:0] i_payload,
    output logic         o_ready,
    input  logic         i_accept_next,
    input  logic         i_clear,
    output logic         o_held_next,
    output logic [W-1:0] o_payload
);

    logic         held_q, held_d;
    logic         ready_q, ready_d;
    logic [W-1:0] payload_q, payload_d;

    always_comb begin
        held_d    = held_q;
        payload_d = payload_q;
        if (i_clear) begin
            held_d = 1'b0;
        end else if (i_valid && ready_q) begin
            held_d    = 1'b1;
            payload_d = i_payload;
        end
        ready_d = i_accept_next && !held_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            held_q    <= 1'b0;
            ready_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            held_q    <= held_d;
            ready_q   <= ready_d;
            payload_q <= payload_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_held_next = held_d;
    assign o_payload   = payload_q;

endmodule

`default_nettype wire

// File: rtl/axi_fifo_write_bridge.sv
// ============================================================================
// Module   : axi_fifo_write_bridge
// Brief    : AXI4-Lite write slave pushing one word per write into a PL FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_fifo_write_bridge
    import axi_fifo_write_bridge_pkg::*;
#(
    parameter int               ADDR_W       = 9,
    parameter int               DATA_W       = 32,
    parameter logic [ADDR_W-1:0] PUSH_ADDR   = '0,
    parameter int               FULL_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    output logic [DATA_W-1:0]   fifo_data_out,
    output logic                fifo_wr_en,
    input  logic                fifo_full,
    output logic [15:0]         err_cnt
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(FULL_TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [15:0]         err_q, err_d;

    logic                aw_held_next, w_held_next;
    logic [ADDR_W-1:0]   aw_addr;
    logic [DATA_W-1:0]   w_data;
    logic [STRB_W-1:0]   w_strb;
    logic                b_hs;
    logic                accept_next;
    logic                ok;

    assign b_hs = (state_q == ST_RESP) && bvalid_q && s_axi_bready;
    // Next state is IDLE exactly when we are idle now or B completes; an IDLE
    // that leaves for PUSH has both holds full, so ready stays low regardless.
    assign accept_next = (state_q == ST_IDLE) || b_hs;

    axi_chan_hold #(.W(ADDR_W)) u_aw_hold (
        .clk           (clk),
        .rstn          (rstn),
        .i_valid       (s_axi_awvalid),
        .i_payload     (s_axi_awaddr),
        .o_ready       (s_axi_awready),
        .i_accept_next (accept_next),
        .i_clear       (b_hs),
        .o_held_next   (aw_held_next),
        .o_payload     (aw_addr)
    );

    axi_chan_hold #(.W(STRB_W + DATA_W)) u_w_hold (
        .clk           (clk),
        .rstn          (rstn),
        .i_valid       (s_axi_wvalid),
        .i_payload     ({s_axi_wstrb, s_axi_wdata}),
        .o_ready       (s_axi_wready),
        .i_accept_next (accept_next),
        .i_clear       (b_hs),
        .o_held_next   (w_held_next),
        .o_payload     ({w_strb, w_data})
    );

    assign ok = (aw_addr == PUSH_ADDR) && (&w_strb);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        wr_en_d  = 1'b0;
        data_d   = data_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_held_next && w_held_next) begin
                    state_d = ST_PUSH;
                    cnt_d   = '0;
                end
            end
            ST_PUSH: begin
                if (!ok || (fifo_full && cnt_q == CNT_W'(FULL_TIMEOUT - 1))) begin
                    state_d  = ST_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_SLVERR;
                    err_d    = sat_inc16(err_q);
                end else if (!fifo_full) begin
                    state_d  = ST_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_OKAY;
                    wr_en_d  = 1'b1;
                    data_d   = w_data;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            wr_en_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            wr_en_q  <= wr_en_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign fifo_wr_en    = wr_en_q;
    assign fifo_data_out = data_q;
    assign err_cnt       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_fifo_write_bridge.sv
// ============================================================================
// Module   : tb_axi_fifo_write_bridge
// Brief    : Directed scoreboard bench for axi_fifo_write_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_fifo_write_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [8:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] fdata;
    logic        fwr;
    logic        ffull;
    logic [15:0] err_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] push_q[$];
    logic [1:0]  bresp_q[$];
    logic [15:0] berr_q[$];

    always #5 clk = ~clk;

    axi_fifo_write_bridge #(
        .ADDR_W(9), .DATA_W(32), .PUSH_ADDR(9'h000), .FULL_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready), .fifo_data_out(fdata), .fifo_wr_en(fwr),
        .fifo_full(ffull), .err_cnt(err_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT pushes or completes a B beat.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                if (fwr === 1'b1) begin
                    if (push_q.size() == 0) chk("unexpected_push", {32'h0, fdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                    else chk("push_data", {32'h0, fdata}, {32'h0, push_q.pop_front()});
                end
                if (bvalid === 1'b1 && bready === 1'b1) begin
                    if (bresp_q.size() == 0) chk("unexpected_b", {62'h0, bresp}, 64'hFFFF_FFFF_FFFF_FFFF);
                    else begin
                        chk("bresp", {62'h0, bresp}, {62'h0, bresp_q.pop_front()});
                        chk("err_cnt", {48'h0, err_cnt}, {48'h0, berr_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic send_aw(input logic [8:0] a);
        awaddr  = a;
        awvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (awready) begin
                @(posedge clk); #1;
                awvalid = 1'b0;
                return;
            end
        end
        chk("aw_timeout", 64'd1, 64'd0);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wready) begin
                @(posedge clk); #1;
                wvalid = 1'b0;
                return;
            end
        end
        chk("w_timeout", 64'd1, 64'd0);
        wvalid = 1'b0;
    endtask

    // Counts negedges after the last channel handshake until bvalid is seen.
    task automatic wait_b(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (bvalid) return;
        end
        chk("b_timeout", 64'd1, 64'd0);
    endtask

    task automatic expect_b(input logic [1:0] r, input logic [15:0] e);
        bresp_q.push_back(r);
        berr_q.push_back(e);
    endtask

    task automatic chk_reset_vals();
        chk("rst_awready", {63'h0, awready}, 64'd0);
        chk("rst_wready",  {63'h0, wready},  64'd0);
        chk("rst_bvalid",  {63'h0, bvalid},  64'd0);
        chk("rst_bresp",   {62'h0, bresp},   64'd0);
        chk("rst_wr_en",   {63'h0, fwr},     64'd0);
        chk("rst_data",    {32'h0, fdata},   64'd0);
        chk("rst_err_cnt", {48'h0, err_cnt}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b1; ffull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1;
        rstn = 1'b1;

        // Same-cycle AW/W with the exact latency profile
        push_q.push_back(32'hDEADBEEF);
        expect_b(2'b00, 16'd0);
        fork
            send_aw(9'h000);
            send_w(32'hDEADBEEF, 4'hF);
        join
        @(negedge clk);
        chk("c1_wr_en", {63'h0, fwr}, 64'd0);
        chk("c1_bvalid", {63'h0, bvalid}, 64'd0);
        chk("c1_awready", {63'h0, awready}, 64'd0);
        @(negedge clk);
        chk("c2_wr_en", {63'h0, fwr}, 64'd1);
        chk("c2_bvalid", {63'h0, bvalid}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("c3_awready", {63'h0, awready}, 64'd1);
        chk("c3_wready", {63'h0, wready}, 64'd1);
        chk("c3_wr_en", {63'h0, fwr}, 64'd0);
        chk("c3_bvalid", {63'h0, bvalid}, 64'd0);
        chk("c3_data_hold", {32'h0, fdata}, 64'hDEADBEEF);
        @(posedge clk); #1;

        // W first, AW three cycles later
        push_q.push_back(32'h12345678);
        expect_b(2'b00, 16'd0);
        send_w(32'h12345678, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wfirst_no_push", {63'h0, fwr}, 64'd0);
            chk("wfirst_wready", {63'h0, wready}, 64'd0);
            chk("wfirst_awready", {63'h0, awready}, 64'd1);
            @(posedge clk); #1;
        end
        send_aw(9'h000);
        wait_b(n);
        chk("wfirst_lat", 64'(n), 64'd2);
        @(posedge clk); #1;

        // Bad address, then partial strobe
        expect_b(2'b10, 16'd1);
        fork
            send_aw(9'h004);
            send_w(32'hAAAA0001, 4'hF);
        join
        wait_b(n);
        chk("badaddr_lat", 64'(n), 64'd2);
        chk("badaddr_no_push", {63'h0, fwr}, 64'd0);
        @(posedge clk); #1;
        expect_b(2'b10, 16'd2);
        fork
            send_aw(9'h000);
            send_w(32'hAAAA0002, 4'h3);
        join
        wait_b(n);
        chk("badstrb_no_push", {63'h0, fwr}, 64'd0);
        @(posedge clk); #1;

        // FIFO full for 10 cycles, then released
        ffull = 1'b1;
        push_q.push_back(32'hC0FFEE01);
        expect_b(2'b00, 16'd2);
        fork
            send_aw(9'h000);
            send_w(32'hC0FFEE01, 4'hF);
        join
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("full_no_push", {63'h0, fwr}, 64'd0);
            chk("full_no_b", {63'h0, bvalid}, 64'd0);
            @(posedge clk); #1;
        end
        ffull = 1'b0;
        wait_b(n);
        chk("full_release_lat", 64'(n), 64'd2);
        @(posedge clk); #1;

        // FIFO held full: timeout after TO cycles in PUSH
        ffull = 1'b1;
        expect_b(2'b10, 16'd3);
        fork
            send_aw(9'h000);
            send_w(32'hBAD0BAD0, 4'hF);
        join
        wait_b(n);
        chk("timeout_lat", 64'(n), 64'(TO + 1));
        @(posedge clk); #1;
        ffull = 1'b0;

        // bready held low; a second AW waits for the B handshake
        bready = 1'b0;
        push_q.push_back(32'hA5A5A5A5);
        expect_b(2'b00, 16'd3);
        fork
            send_aw(9'h000);
            send_w(32'hA5A5A5A5, 4'hF);
        join
        wait_b(n);
        @(posedge clk); #1;
        awaddr = 9'h000;
        awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_bvalid", {63'h0, bvalid}, 64'd1);
            chk("stall_bresp", {62'h0, bresp}, 64'd0);
            chk("stall_awready", {63'h0, awready}, 64'd0);
            chk("stall_wready", {63'h0, wready}, 64'd0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(negedge clk);
        chk("stall_hs_awready", {63'h0, awready}, 64'd0);
        @(posedge clk); #1;
        push_q.push_back(32'h11112222);
        expect_b(2'b00, 16'd3);
        @(negedge clk);
        chk("post_b_awready", {63'h0, awready}, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        send_w(32'h11112222, 4'hF);
        wait_b(n);
        chk("second_lat", 64'(n), 64'd2);
        @(posedge clk); #1;

        // Reset while waiting on a full FIFO
        ffull = 1'b1;
        fork
            send_aw(9'h000);
            send_w(32'hCAFEF00D, 4'hF);
        join
        repeat (5) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1;
        rstn = 1'b1;
        ffull = 1'b0;
        push_q.push_back(32'h0BADF00D);
        expect_b(2'b00, 16'd0);
        fork
            send_aw(9'h000);
            send_w(32'h0BADF00D, 4'hF);
        join
        wait_b(n);
        chk("post_rst_lat", 64'(n), 64'd2);
        @(posedge clk); #1;

        repeat (4) @(posedge clk);
        #1;
        chk("push_q_drained", 64'(push_q.size()), 64'd0);
        chk("b_q_drained", 64'(bresp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
